// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: FIFO stage between the UART receiver and transmitter.
// Each rising rx_ready level is captured once. The byte is dropped with
// err_count++ if rx_error is set, or with overflow set if the FIFO is full.
// The FIFO drains into the transmitter over a start/done handshake, and
// OFFSET is added to each byte as it leaves.
//
// Ports:
//   rst, clk               async active-high reset, rising-edge clock
//   rx_ready/rx_error/rx_data  receiver level interface
//   tx_data, tx_start      byte and request to the transmitter
//   tx_done                transmitter completion level
//   count                  FIFO occupancy 0..DEPTH
//   overflow               sticky drop-on-full flag
//   err_count              saturating count of rx_error rejections
module uart_echo_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter logic [7:0]  OFFSET = 8'h01
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              rx_ready,
  input  logic              rx_error,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        err_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                rx_ready_q;
  logic                edge_c;
  logic                full_c;
  logic                empty_c;
  logic                push_c;
  logic                pop_c;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [7:0]          mem [DEPTH];

  // Capture qualification; full is judged on pre-pop occupancy
  assign edge_c  = rx_ready & ~rx_ready_q;
  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign push_c  = edge_c & ~rx_error & ~full_c;

  // Request is a pure decode of the registered state
  assign tx_start = (state == SEND);

  // TX handshake next-state and pop decision
  always_comb begin
    state_next = state;
    pop_c      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_c) begin
          pop_c      = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (tx_done) state_next = RELEASE;
      end
      RELEASE: begin
        if (!tx_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointers, occupancy, status and output byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_ready_q <= 1'b1;  // a level already high at release is ignored
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      err_count  <= '0;
      tx_data    <= '0;
    end else begin
      state      <= state_next;
      rx_ready_q <= rx_ready;
      if (push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_c) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        tx_data <= mem[rd_ptr] + OFFSET;
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (edge_c && !rx_error && full_c) overflow <= 1'b1;
      if (edge_c && rx_error && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench for uart_echo_buffer: vector table plus directed sequences.
module tb_uart_echo_buffer;

  logic       rst;
  logic       clk;
  logic       rx_ready;
  logic       rx_error;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] err_count;

  logic       auto_ack;
  logic       man_done;
  logic       start_prev;
  logic [7:0] txlog[$];

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [7:0] exp_tx;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vecs[8];

  uart_echo_buffer #(.DEPTH(16), .ADDR_W(4), .OFFSET(8'h01)) dut (
    .rst       (rst),
    .clk       (clk),
    .rx_ready  (rx_ready),
    .rx_error  (rx_error),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .count     (count),
    .overflow  (overflow),
    .err_count (err_count)
  );

  // Transmitter model: either immediate acknowledge or manual control
  assign tx_done = auto_ack ? tx_start : man_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every transmitted byte at the rise of tx_start
  always @(negedge clk) begin
    if (tx_start && !start_prev) txlog.push_back(tx_data);
    start_prev <= tx_start;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_log(input string name, input int idx, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'hxx;
    if (idx < txlog.size()) got = txlog[idx];
    check(name, 32'(got), 32'(exp));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] d, input logic e, input int gap);
    rx_data  = d;
    rx_error = e;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(gap);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic drain_one(output bit ok);
    bit a;
    bit b;
    wait_start(a);
    man_done = 1'b1;
    b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (!tx_start) begin
        b = 1'b1;
        break;
      end
    end
    man_done = 1'b0;
    tick(1);
    ok = a && b;
  endtask

  task automatic do_reset();
    rx_ready = 1'b0;
    rx_error = 1'b0;
    man_done = 1'b0;
    auto_ack = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    bit ok;
    bit all_ok;
    int base;
    int guard;

    pass_cnt  = 0;
    total_cnt = 0;
    rx_data   = 8'h00;
    start_prev = 1'b0;

    vecs[0] = '{data: 8'h00, err: 1'b0, exp_tx: 8'h01, exp_err: 8'd0};
    vecs[1] = '{data: 8'h41, err: 1'b0, exp_tx: 8'h42, exp_err: 8'd0};
    vecs[2] = '{data: 8'h7F, err: 1'b0, exp_tx: 8'h80, exp_err: 8'd0};
    vecs[3] = '{data: 8'h55, err: 1'b1, exp_tx: 8'h00, exp_err: 8'd1};
    vecs[4] = '{data: 8'hFE, err: 1'b0, exp_tx: 8'hFF, exp_err: 8'd1};
    vecs[5] = '{data: 8'hFF, err: 1'b0, exp_tx: 8'h00, exp_err: 8'd1};
    vecs[6] = '{data: 8'hAA, err: 1'b1, exp_tx: 8'h00, exp_err: 8'd2};
    vecs[7] = '{data: 8'h80, err: 1'b0, exp_tx: 8'h81, exp_err: 8'd2};

    // Reset state
    do_reset();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    // Single byte with a long rx_ready level; latency of two clocks
    base = txlog.size();
    rx_data  = 8'h41;
    rx_error = 1'b0;
    rx_ready = 1'b1;
    tick(1);
    check("single_count_after_push", 32'(count), 32'd1);
    check("single_start_early", 32'(tx_start), 32'd0);
    tick(1);
    check("single_start_latency", 32'(tx_start), 32'd1);
    check("single_tx_data", 32'(tx_data), 32'h42);
    check("single_count_after_pop", 32'(count), 32'd0);
    tick(18);
    drain_one(ok);
    check("single_handshake", 32'(ok), 32'd1);
    tick(10);
    check("single_one_tx", 32'(txlog.size() - base), 32'd1);
    check_log("single_logged", base, 8'h42);
    check("single_idle_start", 32'(tx_start), 32'd0);
    check("single_count_end", 32'(count), 32'd0);
    rx_ready = 1'b0;
    tick(1);

    // Vector table: data path, offset wrap and error rejection
    do_reset();
    foreach (vecs[i]) begin
      base = txlog.size();
      pulse(vecs[i].data, vecs[i].err, 1);
      if (!vecs[i].err) begin
        drain_one(ok);
        check($sformatf("vec%0d_handshake", i), 32'(ok), 32'd1);
        check_log($sformatf("vec%0d_tx_data", i), base, vecs[i].exp_tx);
      end else begin
        tick(4);
        check($sformatf("vec%0d_no_tx", i), 32'(txlog.size() - base), 32'd0);
      end
      check($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_count", i), 32'(count), 32'd0);
    end

    // Burst of five while the transmitter is stalled
    do_reset();
    base = txlog.size();
    for (int i = 0; i < 5; i++) pulse(8'(32'h10 + i), 1'b0, 1);
    check("burst_count_peak", 32'(count), 32'd4);
    check("burst_start_held", 32'(tx_start), 32'd1);
    all_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drain_one(ok);
      all_ok = all_ok && ok;
    end
    check("burst_handshakes", 32'(all_ok), 32'd1);
    for (int i = 0; i < 5; i++)
      check_log($sformatf("burst_byte%0d", i), base + i, 8'(32'h11 + i));
    check("burst_count_end", 32'(count), 32'd0);

    // Overflow: 18 bytes, one in SEND, 16 stored, one dropped
    do_reset();
    base = txlog.size();
    for (int i = 0; i < 18; i++) pulse(8'(32'h30 + i), 1'b0, 1);
    check("ovf_count_full", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    all_ok = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drain_one(ok);
      all_ok = all_ok && ok;
    end
    check("ovf_handshakes", 32'(all_ok), 32'd1);
    tick(20);
    check("ovf_tx_total", 32'(txlog.size() - base), 32'd17);
    check_log("ovf_first", base, 8'h31);
    check_log("ovf_last", base + 16, 8'h41);
    check("ovf_idle_start", 32'(tx_start), 32'd0);
    check("ovf_count_end", 32'(count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Error path and saturation
    do_reset();
    pulse(8'hAA, 1'b1, 1);
    check("err_first", 32'(err_count), 32'd1);
    check("err_no_push", 32'(count), 32'd0);
    for (int i = 1; i < 300; i++) pulse(8'hAA, 1'b1, 1);
    check("err_saturated", 32'(err_count), 32'd255);
    check("err_no_push_end", 32'(count), 32'd0);
    check("err_no_start", 32'(tx_start), 32'd0);

    // Streaming 40 bytes with immediate acknowledge across pointer wrap
    do_reset();
    auto_ack = 1'b1;
    base = txlog.size();
    for (int i = 0; i < 40; i++) pulse(8'(32'hE0 + i), 1'b0, 2);
    guard = 0;
    while ((count != 5'd0 || tx_start) && guard < 200) begin
      tick(1);
      guard++;
    end
    check("wrap_drain_timeout", 32'(guard < 200), 32'd1);
    tick(5);
    check("wrap_tx_total", 32'(txlog.size() - base), 32'd40);
    for (int i = 0; i < 40; i++)
      check_log($sformatf("wrap_byte%0d", i), base + i, 8'(32'hE1 + i));
    check("wrap_no_overflow", 32'(overflow), 32'd0);
    auto_ack = 1'b0;

    // Asynchronous reset mid-SEND with rx_ready held across release
    do_reset();
    pulse(8'h50, 1'b0, 1);
    pulse(8'h51, 1'b0, 1);
    pulse(8'h52, 1'b0, 1);
    check("rst_mid_count_pre", 32'(count), 32'd2);
    check("rst_mid_start_pre", 32'(tx_start), 32'd1);
    @(posedge clk);
    #3;
    rx_data  = 8'h60;
    rx_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_mid_start_drop", 32'(tx_start), 32'd0);
    check("rst_mid_count_clear", 32'(count), 32'd0);
    #2;
    rst = 1'b0;
    tick(4);
    check("rst_held_no_capture_count", 32'(count), 32'd0);
    check("rst_held_no_capture_start", 32'(tx_start), 32'd0);
    base = txlog.size();
    rx_ready = 1'b0;
    tick(1);
    rx_ready = 1'b1;
    tick(2);
    check("rst_recapture_start", 32'(tx_start), 32'd1);
    check("rst_recapture_data", 32'(tx_data), 32'h61);
    drain_one(ok);
    check("rst_recapture_handshake", 32'(ok), 32'd1);
    rx_ready = 1'b0;
    tick(3);
    check("rst_recapture_one_tx", 32'(txlog.size() - base), 32'd1);
    check("rst_recapture_count_end", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
